// File: rtl/reg_share_arb_pkg.sv
// rtl/reg_share_arb_pkg.sv - shared types, defaults and index-width helper for reg_share_arb
package reg_share_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;
  localparam int HCNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Width of a requester index; never below one bit so ports stay legal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_share_arb_pick.sv
// rtl/reg_share_arb_pick.sv - rr_pick: combinational round-robin winner selection
module rr_pick
  import reg_share_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = idx_w(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int          j;
  logic [IW-1:0] jj;

  // Scan upward from ptr with wrap; the first requesting index wins.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j  = (int'(ptr) + k) % NREQ;
      jj = j[IW-1:0];
      if (!any && req[jj]) begin
        any     = 1'b1;
        win[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin shared-register arbiter, falling-edge clocked; optional lock/hold via REG_SHARE_ARB_LOCK_EN
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int MAXHOLD = 4
) (
  input  logic                    c,
  input  logic                    rn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  input  logic [NREQ-1:0]         lock,
  output logic [NREQ-1:0]         gnt,
  output logic [idx_w(NREQ)-1:0]  owner,
  output logic [DW-1:0]           q,
  output logic                    qv
);

  localparam int IW = idx_w(NREQ);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   owner_d;
  logic [DW-1:0]   q_d;
  logic            qv_d;

  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            hold_keep;
  logic            hold_enter;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef REG_SHARE_ARB_LOCK_EN
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  // Holder keeps the bus while it still requests, still locks and has budget left.
  assign hold_keep  = (state_q == ST_HOLD) && req[owner] && lock[owner] &&
                      (hcnt_q < HCNT_W'(MAXHOLD));
  assign hold_enter = pick_any && |(pick_win & lock);

  // Hold counter includes the grant edge that entered HOLD.
  always_comb begin
    hcnt_d = '0;
    if (hold_keep)       hcnt_d = hcnt_q + HCNT_W'(1);
    else if (hold_enter) hcnt_d = HCNT_W'(1);
  end

  // Hold counter register.
  always_ff @(negedge c or negedge rn) begin
    if (!rn) hcnt_q <= '0;
    else     hcnt_q <= hcnt_d;
  end
`else
  logic unused_cfg;

  assign hold_keep  = 1'b0;
  assign hold_enter = 1'b0;
  assign unused_cfg = ^lock ^ (MAXHOLD > 0) ^ (state_q == ST_HOLD);
`endif

  // State and registered outputs; reset is immediate, updates on the falling edge.
  always_ff @(negedge c or negedge rn) begin
    if (!rn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt     <= '0;
      owner   <= '0;
      q       <= '0;
      qv      <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      q       <= q_d;
      qv      <= qv_d;
    end
  end

  // Next state: stay in HOLD while allowed, otherwise arbitrate or go idle.
  always_comb begin
    state_d = ST_IDLE;
    if (hold_keep)     state_d = ST_HOLD;
    else if (pick_any) state_d = hold_enter ? ST_HOLD : ST_GRANT;
  end

  // Output/datapath next values; ptr already sits past the holder, so HOLD leaves it alone.
  always_comb begin
    gnt_d   = '0;
    owner_d = '0;
    q_d     = q;
    qv_d    = 1'b0;
    ptr_d   = ptr_q;
    if (hold_keep) begin
      gnt_d   = gnt;
      owner_d = owner;
      q_d     = wdata[int'(owner)*DW +: DW];
      qv_d    = 1'b1;
    end else if (pick_any) begin
      gnt_d   = pick_win;
      owner_d = pick_idx;
      q_d     = wdata[int'(pick_idx)*DW +: DW];
      qv_d    = 1'b1;
      ptr_d   = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - scoreboard bench for reg_share_arb with randomized stimulus and reference model
module tb_reg_share_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
`ifdef REG_SHARE_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        c     = 1'b1;
  logic        rn    = 1'b0;
  logic [3:0]  req   = '0;
  logic [3:0]  lock  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        qv;

  reg_share_arb #(.NREQ(N), .DW(W), .MAXHOLD(MH)) dut (
    .c     (c),
    .rn    (rn),
    .req   (req),
    .wdata (wdata),
    .lock  (lock),
    .gnt   (gnt),
    .owner (owner),
    .q     (q),
    .qv    (qv)
  );

  always #5 c = ~c;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [7:0] q;
    logic       qv;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  // Reference model state: next pointer, current holder (-1 none), cycles held, last register value.
  int         m_ptr    = 0;
  int         m_holder = -1;
  int         m_hcnt   = 0;
  logic [7:0] m_q      = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // Predict the outputs after the coming falling edge.
  task automatic model_step(input logic rst_v, input logic [3:0] r, input logic [3:0] l,
                            input logic [31:0] wd);
    exp_t e;
    int   w;
    e.gnt = '0; e.owner = '0; e.qv = 1'b0; w = -1;
    if (rst_v) begin
      m_ptr = 0; m_holder = -1; m_hcnt = 0; m_q = '0;
    end else if (LOCK_EN && m_holder >= 0 && r[m_holder] && l[m_holder] && m_hcnt < MH) begin
      m_hcnt++;
      w = m_holder;
    end else begin
      m_holder = -1; m_hcnt = 0;
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_ptr = (w + 1) % N;
        if (LOCK_EN && l[w]) begin m_holder = w; m_hcnt = 1; end
      end
    end
    if (w >= 0) begin
      e.gnt   = 4'(1 << w);
      e.owner = 2'(w);
      e.qv    = 1'b1;
      m_q     = wd[w*8 +: 8];
    end
    e.q = m_q;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rn_v, input logic [3:0] r, input logic [3:0] l,
                       input logic [31:0] wd);
    @(posedge c);
    rn = rn_v; req = r; lock = l; wdata = wd;
    model_step(!rn_v, r, l, wd);
  endtask

  // Monitor: after each falling edge compare DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge c);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt",   32'(gnt),   32'(e.gnt));
        chk("owner", 32'(owner), 32'(e.owner));
        chk("q",     32'(q),     32'(e.q));
        chk("qv",    32'(qv),    32'(e.qv));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    #1;
    chk("reset_gnt",   32'(gnt),   32'h0);
    chk("reset_owner", 32'(owner), 32'h0);
    chk("reset_q",     32'(q),     32'h0);
    chk("reset_qv",    32'(qv),    32'h0);

    repeat (2) drive(1'b0, 4'b1111, 4'b0000, 32'h44332211);
    repeat (5) drive(1'b1, 4'b1111, 4'b0000, 32'h44332211);

    drive(1'b1, 4'b0000, 4'b0000, 32'h99999999);
    drive(1'b1, 4'b0000, 4'b0000, 32'h99999999);
    #2 req = 4'b1111; wdata = 32'hAABBCCDD;
    #1 req = 4'b0000;
    drive(1'b1, 4'b0000, 4'b0000, 32'h12345678);

    drive(1'b1, 4'b0100, 4'b0000, 32'h00C30000);
    repeat (3) drive(1'b1, 4'b0101, 4'b0000, 32'hD4C3B2A1);

    repeat (7) drive(1'b1, 4'b0011, 4'b0010, 32'h5A5A2B1C);

    repeat (2) drive(1'b1, 4'b0010, 4'b0010, 32'h00007700);
    drive(1'b0, 4'b0011, 4'b0010, 32'h0000EE01);
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_q",   32'(q),   32'h0);
    chk("async_rst_qv",  32'(qv),  32'h0);
    repeat (3) drive(1'b1, 4'b0011, 4'b0010, 32'h0000EE01);

    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 39) != 0), 4'($urandom), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
            $urandom);

    drive(1'b1, 4'b0000, 4'b0000, 32'h0);
    @(negedge c);
    #4;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
